// File: rtl/riscv_lsu_if.sv
// Request/response and data-bus bundles for the load/store unit.
// Execute stage drives req_*, the LSU drives the bus strobes.
interface riscv_lsu_req_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [4:0]            req_rd;
  logic                  resp_valid;
  logic                  resp_fault;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic [4:0]            resp_rd;

  modport master (
    output req_valid, req_write, req_funct3,
    output req_addr, req_wdata, req_rd,
    input  req_ready, resp_valid, resp_fault,
    input  resp_rdata, resp_rd
  );

  modport slave (
    input  req_valid, req_write, req_funct3,
    input  req_addr, req_wdata, req_rd,
    output req_ready, resp_valid, resp_fault,
    output resp_rdata, resp_rd
  );
endinterface

interface riscv_lsu_bus_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   bus_addr;
  logic [DATA_WIDTH/8-1:0] bus_byte_en;
  logic [DATA_WIDTH-1:0]   bus_wdata;
  logic                    bus_read;
  logic                    bus_write;
  logic                    bus_ready;
  logic [DATA_WIDTH-1:0]   bus_rdata;
  logic                    bus_error;

  modport master (
    output bus_addr, bus_byte_en, bus_wdata,
    output bus_read, bus_write,
    input  bus_ready, bus_rdata, bus_error
  );

  modport slave (
    input  bus_addr, bus_byte_en, bus_wdata,
    input  bus_read, bus_write,
    output bus_ready, bus_rdata, bus_error
  );
endinterface

// File: rtl/riscv_lsu.sv
// Handshaked load/store unit: one request at a time, word bus
// with byte enables, wait states, optional two-beat split.
module riscv_lsu #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int ALLOW_MISALIGNED = 0,
  parameter int WAIT_LIMIT       = 0
) (
  input logic             clock,
  input logic             reset,
  riscv_lsu_req_if.slave  req,
  riscv_lsu_bus_if.master bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OW    = $clog2(BYTES);
  localparam int WW    = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam int WLIM  = (WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t                state, state_nx;
  logic [OW-1:0]         off, off_q, lowm;
  logic [1:0]            sz, sz_q;
  logic                  uns_q, wr_q, split_q;
  logic [4:0]            rd_q;
  logic [BYTES-1:0]      be1_q;
  logic [DATA_WIDTH-1:0] wd1_q, rd0_q;
  logic [WW-1:0]         wcnt;
  logic                  rdy, accept, bad, split;
  logic                  beat, done, tout, abort;
  logic [2*BYTES-1:0]    m, be_w;
  logic [2*DATA_WIDTH-1:0] wd_w;
  logic [DATA_WIDTH-1:0] lo, hi, raw, msk, ld;
  logic                  sgn;

  assign rdy           = (state == IDLE) || (state == RESP);
  assign req.req_ready = rdy;
  assign accept        = req.req_valid && rdy;
  assign beat          = (state == BEAT0) || (state == BEAT1);
  assign done          = beat && bus.bus_ready;
  assign tout          = (WAIT_LIMIT > 0) && beat &&
                         !bus.bus_ready && (wcnt == WW'(WLIM));
  assign abort         = (done && bus.bus_error) || tout;

  // Request decode: legality, alignment, lane placement of both beats
  always_comb begin
    off  = req.req_addr[OW-1:0];
    sz   = req.req_funct3[1:0];
    lowm = OW'((8'd1 << sz) - 8'd1);
    bad  = (req.req_write && req.req_funct3[2]) ||
           (DATA_WIDTH == 32 && sz == 2'd3) ||
           (req.req_funct3 == 3'd7) ||
           ((ALLOW_MISALIGNED == 0) && ((off & lowm) != '0));
    split = (ALLOW_MISALIGNED != 0) &&
            ((32'(off) + (32'd1 << sz)) > 32'(BYTES));
    unique case (sz)
      2'd0:    m = (2*BYTES)'(8'h01);
      2'd1:    m = (2*BYTES)'(8'h03);
      2'd2:    m = (2*BYTES)'(8'h0F);
      default: m = (2*BYTES)'(8'hFF);
    endcase
    be_w = m << off;
    wd_w = {{DATA_WIDTH{1'b0}}, req.req_wdata} << {off, 3'b000};
  end

  // Load merge of one or two beats, then sign/zero extension
  always_comb begin
    lo  = (state == BEAT1) ? rd0_q : bus.bus_rdata;
    hi  = (state == BEAT1) ? bus.bus_rdata : '0;
    raw = DATA_WIDTH'({hi, lo} >> {off_q, 3'b000});
    unique case (sz_q)
      2'd0: begin
        msk = DATA_WIDTH'(8'hFF);
        sgn = raw[7];
      end
      2'd1: begin
        msk = DATA_WIDTH'(16'hFFFF);
        sgn = raw[15];
      end
      2'd2: begin
        msk = DATA_WIDTH'(32'hFFFF_FFFF);
        sgn = raw[31];
      end
      default: begin
        msk = '1;
        sgn = raw[DATA_WIDTH-1];
      end
    endcase
    ld = (raw & msk) | ((!uns_q && sgn) ? ~msk : '0);
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, RESP: begin
        if (accept) state_nx = bad ? RESP : BEAT0;
        else        state_nx = IDLE;
      end
      BEAT0: begin
        if (abort)     state_nx = RESP;
        else if (done) state_nx = split_q ? BEAT1 : RESP;
      end
      BEAT1: begin
        if (abort || done) state_nx = RESP;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Request capture, bus beats and response registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      off_q           <= '0;
      sz_q            <= '0;
      uns_q           <= 1'b0;
      wr_q            <= 1'b0;
      split_q         <= 1'b0;
      rd_q            <= '0;
      be1_q           <= '0;
      wd1_q           <= '0;
      rd0_q           <= '0;
      wcnt            <= '0;
      bus.bus_addr    <= '0;
      bus.bus_byte_en <= '0;
      bus.bus_wdata   <= '0;
      bus.bus_read    <= 1'b0;
      bus.bus_write   <= 1'b0;
      req.resp_valid  <= 1'b0;
      req.resp_fault  <= 1'b0;
      req.resp_rdata  <= '0;
      req.resp_rd     <= '0;
    end else begin
      req.resp_valid <= 1'b0;
      if (accept) begin
        off_q   <= off;
        sz_q    <= sz;
        uns_q   <= req.req_funct3[2];
        wr_q    <= req.req_write;
        split_q <= split;
        rd_q    <= req.req_rd;
        be1_q   <= be_w[2*BYTES-1:BYTES];
        wd1_q   <= wd_w[2*DATA_WIDTH-1:DATA_WIDTH];
        wcnt    <= '0;
        if (!bad) begin
          bus.bus_addr    <= {req.req_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
          bus.bus_byte_en <= be_w[BYTES-1:0];
          bus.bus_wdata   <= wd_w[DATA_WIDTH-1:0];
          bus.bus_read    <= !req.req_write;
          bus.bus_write   <= req.req_write;
        end
      end
      if (beat) begin
        if (done && !abort && state == BEAT0 && split_q) begin
          bus.bus_addr    <= bus.bus_addr + ADDR_WIDTH'(BYTES);
          bus.bus_byte_en <= be1_q;
          bus.bus_wdata   <= wd1_q;
          rd0_q           <= bus.bus_rdata;
          wcnt            <= '0;
        end else if (done || abort) begin
          bus.bus_read  <= 1'b0;
          bus.bus_write <= 1'b0;
        end else begin
          wcnt <= wcnt + WW'(1);
        end
      end
      if (state_nx == RESP) begin
        req.resp_valid <= 1'b1;
        req.resp_rd    <= accept ? req.req_rd : rd_q;
        req.resp_fault <= accept || abort;
        req.resp_rdata <= (accept || abort || wr_q) ? '0 : ld;
      end
    end
  end
endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: u_a is strict-aligned with no
// timeout, u_b splits misaligned accesses and times out after 4.
module tb_riscv_lsu;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sel;
  logic        v, w, rdy, err;
  logic [2:0]  f3;
  logic [31:0] addr, wd, rdat;
  logic [4:0]  rd;
  int          n_vec = 0;
  int          n_err = 0;
  int          cnt, seen, bad;

  logic [31:0] o_rdy, o_rv, o_rf, o_rdata, o_rdreg;
  logic [31:0] o_baddr, o_be, o_bwd, o_brd, o_bwr;

  riscv_lsu_req_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ra ();
  riscv_lsu_req_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) rb ();
  riscv_lsu_bus_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ba ();
  riscv_lsu_bus_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bb ();

  riscv_lsu #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .ALLOW_MISALIGNED(0), .WAIT_LIMIT(0)
  ) u_a (
    .clock(clock), .reset(reset), .req(ra), .bus(ba)
  );

  riscv_lsu #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .ALLOW_MISALIGNED(1), .WAIT_LIMIT(4)
  ) u_b (
    .clock(clock), .reset(reset), .req(rb), .bus(bb)
  );

  assign ra.req_valid  = v && !sel;
  assign rb.req_valid  = v && sel;
  assign ra.req_write  = w;
  assign rb.req_write  = w;
  assign ra.req_funct3 = f3;
  assign rb.req_funct3 = f3;
  assign ra.req_addr   = addr;
  assign rb.req_addr   = addr;
  assign ra.req_wdata  = wd;
  assign rb.req_wdata  = wd;
  assign ra.req_rd     = rd;
  assign rb.req_rd     = rd;
  assign ba.bus_ready  = rdy && !sel;
  assign bb.bus_ready  = rdy && sel;
  assign ba.bus_rdata  = rdat;
  assign bb.bus_rdata  = rdat;
  assign ba.bus_error  = err;
  assign bb.bus_error  = err;

  assign o_rdy   = 32'(sel ? rb.req_ready : ra.req_ready);
  assign o_rv    = 32'(sel ? rb.resp_valid : ra.resp_valid);
  assign o_rf    = 32'(sel ? rb.resp_fault : ra.resp_fault);
  assign o_rdata = sel ? rb.resp_rdata : ra.resp_rdata;
  assign o_rdreg = 32'(sel ? rb.resp_rd : ra.resp_rd);
  assign o_baddr = sel ? bb.bus_addr : ba.bus_addr;
  assign o_be    = 32'(sel ? bb.bus_byte_en : ba.bus_byte_en);
  assign o_bwd   = sel ? bb.bus_wdata : ba.bus_wdata;
  assign o_brd   = 32'(sel ? bb.bus_read : ba.bus_read);
  assign o_bwr   = 32'(sel ? bb.bus_write : ba.bus_write);

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic iw, input logic [2:0] if3,
                       input logic [31:0] ia, input logic [31:0] iwd,
                       input logic [4:0] ird);
    w = iw; f3 = if3; addr = ia; wd = iwd; rd = ird;
    v = 1'b1;
    tick();
    v = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic e);
    rdy = 1'b1; rdat = d; err = e;
    tick();
    rdy = 1'b0; err = 1'b0; rdat = '0;
  endtask

  initial begin
    sel = 1'b0; v = 1'b0; w = 1'b0; f3 = '0;
    addr = '0; wd = '0; rd = '0;
    rdy = 1'b0; err = 1'b0; rdat = '0;
    repeat (2) tick();
    chk("rst_ready_a", o_rdy, 1);
    chk("rst_read_a", o_brd, 0);
    chk("rst_be_a", o_be, 0);
    chk("rst_rv_a", o_rv, 0);
    sel = 1'b1;
    chk("rst_ready_b", o_rdy, 1);
    chk("rst_write_b", o_bwr, 0);
    sel = 1'b0;
    reset = 1'b1;
    tick();

    issue(0, 3'b010, 32'h100, 0, 5'd7);
    chk("lw_read", o_brd, 1);
    chk("lw_addr", o_baddr, 32'h100);
    chk("lw_be", o_be, 'hF);
    chk("lw_busy", o_rdy, 0);
    chk("lw_early", o_rv, 0);
    beat(32'hDEADBEEF, 0);
    chk("lw_rv", o_rv, 1);
    chk("lw_data", o_rdata, 32'hDEADBEEF);
    chk("lw_fault", o_rf, 0);
    chk("lw_rd", o_rdreg, 7);
    chk("lw_drop", o_brd, 0);
    tick();
    chk("lw_pulse", o_rv, 0);
    chk("lw_hold", o_rdata, 32'hDEADBEEF);

    issue(0, 3'b000, 32'h103, 0, 5'd3);
    chk("lb_be", o_be, 'h8);
    beat(32'h80123456, 0);
    chk("lb_data", o_rdata, 32'hFFFFFF80);
    issue(0, 3'b100, 32'h103, 0, 5'd4);
    chk("lbu_b2b_read", o_brd, 1);
    beat(32'h80123456, 0);
    chk("lbu_data", o_rdata, 32'h00000080);
    chk("lbu_rd", o_rdreg, 4);
    tick();
    issue(0, 3'b001, 32'h102, 0, 5'd5);
    chk("lh_be", o_be, 'hC);
    beat(32'h80012345, 0);
    chk("lh_data", o_rdata, 32'hFFFF8001);

    tick();
    issue(1, 3'b001, 32'h203, 32'h0000ABCD, 5'd0);
    chk("shmis_write", o_bwr, 0);
    chk("shmis_rv", o_rv, 1);
    chk("shmis_fault", o_rf, 1);
    chk("shmis_data", o_rdata, 0);
    tick();
    issue(0, 3'b011, 32'h100, 0, 5'd1);
    chk("ld32_read", o_brd, 0);
    chk("ld32_fault", o_rf, 1);
    tick();
    issue(0, 3'b010, 32'h102, 0, 5'd2);
    chk("lwmis_read", o_brd, 0);
    chk("lwmis_rv", o_rv, 1);
    tick();
    issue(1, 3'b110, 32'h100, 0, 5'd2);
    chk("sbu_write", o_bwr, 0);
    chk("sbu_rv", o_rv, 1);
    tick();

    sel = 1'b1;
    issue(1, 3'b001, 32'h203, 32'h0000ABCD, 5'd0);
    chk("sh0_write", o_bwr, 1);
    chk("sh0_addr", o_baddr, 32'h200);
    chk("sh0_be", o_be, 'h8);
    chk("sh0_wd", o_bwd, 32'hCD000000);
    beat(0, 0);
    chk("sh1_write", o_bwr, 1);
    chk("sh1_addr", o_baddr, 32'h204);
    chk("sh1_be", o_be, 'h1);
    chk("sh1_wd", o_bwd, 32'h000000AB);
    chk("sh1_rv", o_rv, 0);
    beat(0, 0);
    chk("sh_rv", o_rv, 1);
    chk("sh_fault", o_rf, 0);
    chk("sh_drop", o_bwr, 0);
    tick();

    issue(0, 3'b010, 32'h102, 0, 5'd9);
    chk("lws0_be", o_be, 'hC);
    beat(32'h44332211, 0);
    chk("lws1_addr", o_baddr, 32'h104);
    chk("lws1_be", o_be, 'h3);
    chk("lws1_rv", o_rv, 0);
    beat(32'h88776655, 0);
    chk("lws_rv", o_rv, 1);
    chk("lws_data", o_rdata, 32'h66554433);
    chk("lws_rd", o_rdreg, 9);
    tick();

    issue(0, 3'b010, 32'h300, 0, 5'd2);
    cnt = 0; seen = 0;
    for (int i = 0; i < 12 && seen == 0; i++) begin
      if (o_brd == 1) cnt++;
      if (o_rv == 1) seen = 1;
      else tick();
    end
    chk("to_cycles", cnt, 4);
    chk("to_resp", seen, 1);
    chk("to_fault", o_rf, 1);
    chk("to_data", o_rdata, 0);
    tick();

    issue(1, 3'b010, 32'h206, 32'h11223344, 5'd0);
    chk("se_write", o_bwr, 1);
    chk("se_be", o_be, 'hC);
    beat(0, 1);
    chk("se_nobeat1", o_bwr, 0);
    chk("se_rv", o_rv, 1);
    chk("se_fault", o_rf, 1);
    tick();

    sel = 1'b0;
    issue(0, 3'b010, 32'h100, 0, 5'd5);
    chk("rs_read", o_brd, 1);
    tick();
    chk("rs_wait", o_brd, 1);
    reset = 1'b0;
    #1;
    chk("rs_async", o_brd, 0);
    repeat (2) tick();
    reset = 1'b1;
    bad = 0;
    repeat (3) begin
      tick();
      if (o_rv != 0) bad = 1;
    end
    chk("rs_no_resp", bad, 0);
    chk("rs_ready", o_rdy, 1);
    issue(0, 3'b010, 32'h104, 0, 5'd6);
    chk("rs_lw_addr", o_baddr, 32'h104);
    beat(32'h12345678, 0);
    chk("rs_lw_data", o_rdata, 32'h12345678);
    chk("rs_lw_rv", o_rv, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
